// File: rtl/spi_slave_responder.sv
// -----------------------------------------------------------------------------
// spi_slave_responder
//
// SPI responder clocked entirely on clk. The SPI pins are oversampled through
// two-flop synchronizers and edges are found by comparing against a third
// register. Supports all four CPOL/CPHA modes. Words are received MSB first
// from mosi and a preloaded word is shifted out MSB first on miso.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   cpol_i       sclk idle level, latched while IDLE
//   cpha_i       0: sample on leading edge, 1: sample on trailing edge
//   sclk_i       SPI clock from master (asynchronous)
//   cs_i         active-low chip select (asynchronous)
//   mosi_i       master-out data (asynchronous)
//   miso_o       slave-out data, 0 while not selected
//   tx_data_i    next word to transmit
//   tx_load_i    write strobe, accepted while tx_ready_o = 1
//   tx_ready_o   holding register empty
//   rx_data_o    last complete received word
//   rx_valid_o   one-cycle pulse when rx_data_o updates
//   frame_err_o  one-cycle pulse when cs rises in the middle of a word
//
// state  | meaning
// IDLE   | not selected, cpol/cpha follow the inputs, sclk edges ignored
// ACTIVE | selected, shifting words in and out
// -----------------------------------------------------------------------------
module spi_slave_responder #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpol_i,
    input  logic              cpha_i,
    input  logic              sclk_i,
    input  logic              cs_i,
    input  logic              mosi_i,
    output logic              miso_o,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_load_i,
    output logic              tx_ready_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    output logic              frame_err_o
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // synchronizers and edge-detect history
    logic sclk_m_q, sclk_s_q, sclk_p_q;
    logic cs_m_q, cs_s_q, cs_p_q;
    logic mosi_m_q, mosi_s_q;

    state_t            state_q, state_d;
    logic              cpol_q, cpol_d;
    logic              cpha_q, cpha_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              tx_ready_q, tx_ready_d;
    logic              miso_q, miso_d;
    logic              pend_q, pend_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              frame_err_q, frame_err_d;

    logic              sclk_chg, lead_edge, trail_edge;
    logic              sample_edge, shift_edge;
    logic              cs_fall, cs_rise;
    logic              reload;
    logic [DATA_W-1:0] reload_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_m_q <= 1'b0;
            sclk_s_q <= 1'b0;
            sclk_p_q <= 1'b0;
            cs_m_q   <= 1'b1;
            cs_s_q   <= 1'b1;
            cs_p_q   <= 1'b1;
            mosi_m_q <= 1'b0;
            mosi_s_q <= 1'b0;
        end else begin
            sclk_m_q <= sclk_i;
            sclk_s_q <= sclk_m_q;
            sclk_p_q <= sclk_s_q;
            cs_m_q   <= cs_i;
            cs_s_q   <= cs_m_q;
            cs_p_q   <= cs_s_q;
            mosi_m_q <= mosi_i;
            mosi_s_q <= mosi_m_q;
        end
    end

    assign sclk_chg    = sclk_s_q ^ sclk_p_q;
    assign lead_edge   = sclk_chg & (sclk_p_q == cpol_q);
    assign trail_edge  = sclk_chg & (sclk_p_q != cpol_q);
    assign sample_edge = cpha_q ? trail_edge : lead_edge;
    assign shift_edge  = cpha_q ? lead_edge  : trail_edge;
    assign cs_fall     = cs_p_q & ~cs_s_q;
    assign cs_rise     = ~cs_p_q & cs_s_q;

    // an empty holding register transmits zeros
    assign reload_word = tx_ready_q ? '0 : hold_q;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            cnt_q       <= '0;
            rx_sh_q     <= '0;
            tx_sh_q     <= '0;
            hold_q      <= '0;
            tx_ready_q  <= 1'b1;
            miso_q      <= 1'b0;
            pend_q      <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cpol_q      <= cpol_d;
            cpha_q      <= cpha_d;
            cnt_q       <= cnt_d;
            rx_sh_q     <= rx_sh_d;
            tx_sh_q     <= tx_sh_d;
            hold_q      <= hold_d;
            tx_ready_q  <= tx_ready_d;
            miso_q      <= miso_d;
            pend_q      <= pend_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d     = state_q;
        cpol_d      = cpol_q;
        cpha_d      = cpha_q;
        cnt_d       = cnt_q;
        rx_sh_d     = rx_sh_q;
        tx_sh_d     = tx_sh_q;
        hold_d      = hold_q;
        tx_ready_d  = tx_ready_q;
        miso_d      = miso_q;
        pend_d      = pend_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        reload      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cpol_d = cpol_i;
                cpha_d = cpha_i;
                if (cs_fall) begin
                    state_d = ST_ACTIVE;
                    cnt_d   = '0;
                    rx_sh_d = '0;
                    tx_sh_d = reload_word;
                    reload  = 1'b1;
                    // cpha=0 presents the MSB now; cpha=1 waits for the
                    // first leading edge
                    pend_d  = cpha_i;
                    miso_d  = cpha_i ? 1'b0 : reload_word[DATA_W-1];
                end
            end
            ST_ACTIVE: begin
                if (cs_rise) begin
                    state_d     = ST_IDLE;
                    miso_d      = 1'b0;
                    pend_d      = 1'b0;
                    cnt_d       = '0;
                    frame_err_d = (cnt_q != '0);
                end else if (sample_edge) begin
                    rx_sh_d = {rx_sh_q[DATA_W-2:0], mosi_s_q};
                    if (cnt_q == CNT_LAST) begin
                        cnt_d      = '0;
                        rx_data_d  = {rx_sh_q[DATA_W-2:0], mosi_s_q};
                        rx_valid_d = 1'b1;
                        tx_sh_d    = reload_word;
                        reload     = 1'b1;
                        // next shift edge presents the new MSB instead of
                        // shifting
                        pend_d     = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (shift_edge) begin
                    if (pend_q) begin
                        miso_d = tx_sh_q[DATA_W-1];
                        pend_d = 1'b0;
                    end else begin
                        tx_sh_d = tx_sh_q << 1;
                        miso_d  = tx_sh_q[DATA_W-2];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // a reload empties the holding register; a same-cycle load refills it
        if (reload) begin
            tx_ready_d = 1'b1;
        end
        if (tx_load_i && tx_ready_q) begin
            hold_d     = tx_data_i;
            tx_ready_d = 1'b0;
        end
    end

    // outputs
    always_comb begin
        miso_o      = (state_q == ST_ACTIVE) ? miso_q : 1'b0;
        tx_ready_o  = tx_ready_q;
        rx_data_o   = rx_data_q;
        rx_valid_o  = rx_valid_q;
        frame_err_o = frame_err_q;
    end

endmodule

// File: tb/tb_spi_slave_responder.sv
module tb_spi_slave_responder;

    localparam int H = 60;   // sclk half period, 6 clk periods

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cpol, cpha, sclk, cs, mosi;
    logic       miso;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;

    int n_checks = 0;
    int n_pass   = 0;
    int n_ferr   = 0;
    logic [7:0] exp_rx_q[$];

    always #5 clk = ~clk;

    spi_slave_responder #(.DATA_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpol_i     (cpol),
        .cpha_i     (cpha),
        .sclk_i     (sclk),
        .cs_i       (cs),
        .mosi_i     (mosi),
        .miso_o     (miso),
        .tx_data_i  (tx_data),
        .tx_load_i  (tx_load),
        .tx_ready_o (tx_ready),
        .rx_data_o  (rx_data),
        .rx_valid_o (rx_valid),
        .frame_err_o(frame_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // scoreboard side: every rx_valid pulse consumes one expected word
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (rx_valid === 1'b1) begin
                if (exp_rx_q.size() == 0) begin
                    check("rx_valid_unexpected", 32'd1, 32'd0);
                end else begin
                    check("rx_data", {24'd0, rx_data}, {24'd0, exp_rx_q.pop_front()});
                end
            end
            if (frame_err === 1'b1) n_ferr++;
        end
    end

    task automatic set_mode(input logic p, input logic h);
        cpol = p;
        cpha = h;
        sclk = p;
        #100;
    endtask

    task automatic load_tx(input logic [7:0] v);
        tx_data = v;
        tx_load = 1'b1;
        #10;
        tx_load = 1'b0;
    endtask

    // drives nbits of one word with cs already low; returns the miso bits
    // and how many times miso moved right after a sample edge
    task automatic spi_bits(input logic [7:0] dout, input int nbits,
                            output logic [7:0] din, output int unstable);
        logic m;
        din = 8'd0;
        unstable = 0;
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) begin
                mosi = dout[7-i];
                #H;
                m = miso;
                sclk = ~cpol;
                din = {din[6:0], m};
                #40;
                if (miso !== m) unstable++;
                #(H-40);
                sclk = cpol;
            end else begin
                sclk = ~cpol;
                mosi = dout[7-i];
                #H;
                m = miso;
                sclk = cpol;
                din = {din[6:0], m};
                #40;
                if (miso !== m) unstable++;
                #(H-40);
            end
        end
    endtask

    task automatic frame(input logic [7:0] w0, input logic [7:0] w1, input int nwords,
                         input int nbits0, input logic do_load, input logic [7:0] load_v,
                         output logic [7:0] c0, output logic [7:0] c1, output int unstable);
        int u;
        c1 = 8'd0;
        cs = 1'b0;
        #H;
        if (do_load) begin
            check("tx_ready_after_entry", {31'd0, tx_ready}, 32'd1);
            load_tx(load_v);
            check("tx_ready_after_load2", {31'd0, tx_ready}, 32'd0);
        end
        if (nbits0 == 8) exp_rx_q.push_back(w0);
        spi_bits(w0, nbits0, c0, unstable);
        if (nwords > 1) begin
            exp_rx_q.push_back(w1);
            spi_bits(w1, 8, c1, u);
            unstable += u;
        end
        #H;
        cs = 1'b1;
        #H;
        check("miso_idle", {31'd0, miso}, 32'd0);
        mosi = 1'b0;
    endtask

    initial begin : stim
        logic [7:0] c0, c1;
        int unst, ferr0;
        logic [1:0] modes [3];

        rst_n = 1'b0;
        cpol = 1'b0; cpha = 1'b0; sclk = 1'b0; cs = 1'b1; mosi = 1'b0;
        tx_data = 8'd0; tx_load = 1'b0;
        #23;
        check("rst_miso", {31'd0, miso}, 32'd0);
        check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("rst_rx_data", {24'd0, rx_data}, 32'd0);
        check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        #50;

        // mode 0: 0xA3 in, 0x5C out
        set_mode(1'b0, 1'b0);
        load_tx(8'h5C);
        check("tx_ready_after_load", {31'd0, tx_ready}, 32'd0);
        frame(8'hA3, 8'h00, 1, 8, 1'b0, 8'h00, c0, c1, unst);
        check("m0_miso_word", {24'd0, c0}, 32'h5C);
        check("m0_miso_stable", unst, 32'd0);
        check("m0_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("m0_frame_err", n_ferr, 32'd0);
        check("m0_rx_hold", {24'd0, rx_data}, 32'hA3);

        // modes 1, 2, 3
        modes[0] = 2'b01; modes[1] = 2'b10; modes[2] = 2'b11;
        for (int m = 0; m < 3; m++) begin
            set_mode(modes[m][1], modes[m][0]);
            load_tx(8'h5C);
            frame(8'hA3, 8'h00, 1, 8, 1'b0, 8'h00, c0, c1, unst);
            check($sformatf("mode%0d_miso_word", m + 1), {24'd0, c0}, 32'h5C);
            check($sformatf("mode%0d_miso_stable", m + 1), unst, 32'd0);
            check($sformatf("mode%0d_frame_err", m + 1), n_ferr, 32'd0);
        end

        // two words under one cs, second tx word loaded mid-frame
        set_mode(1'b0, 1'b0);
        load_tx(8'hF0);
        frame(8'h12, 8'h34, 2, 8, 1'b1, 8'h0F, c0, c1, unst);
        check("two_miso_w0", {24'd0, c0}, 32'hF0);
        check("two_miso_w1", {24'd0, c1}, 32'h0F);
        check("two_stable", unst, 32'd0);
        check("two_tx_ready", {31'd0, tx_ready}, 32'd1);

        // two words in mode 3 with the same pattern
        set_mode(1'b1, 1'b1);
        load_tx(8'hF0);
        frame(8'h12, 8'h34, 2, 8, 1'b1, 8'h0F, c0, c1, unst);
        check("two_m3_miso_w0", {24'd0, c0}, 32'hF0);
        check("two_m3_miso_w1", {24'd0, c1}, 32'h0F);

        // nothing loaded: zeros out
        set_mode(1'b0, 1'b0);
        frame(8'hFF, 8'h00, 1, 8, 1'b0, 8'h00, c0, c1, unst);
        check("empty_miso_word", {24'd0, c0}, 32'h00);
        check("empty_rx_hold", {24'd0, rx_data}, 32'hFF);

        // cs rises after 5 samples
        ferr0 = n_ferr;
        frame(8'hB7, 8'h00, 1, 5, 1'b0, 8'h00, c0, c1, unst);
        check("abort_frame_err_pulses", n_ferr - ferr0, 32'd1);
        check("abort_rx_kept", {24'd0, rx_data}, 32'hFF);
        frame(8'h81, 8'h00, 1, 8, 1'b0, 8'h00, c0, c1, unst);
        check("after_abort_rx", {24'd0, rx_data}, 32'h81);
        check("after_abort_no_ferr", n_ferr - ferr0, 32'd1);

        // reset in the middle of a frame
        load_tx(8'h66);
        cs = 1'b0;
        #H;
        spi_bits(8'hC5, 3, c0, unst);
        rst_n = 1'b0;
        #1;
        check("midrst_miso", {31'd0, miso}, 32'd0);
        check("midrst_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("midrst_rx_data", {24'd0, rx_data}, 32'd0);
        check("midrst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("midrst_frame_err", {31'd0, frame_err}, 32'd0);
        cs = 1'b1;
        sclk = cpol;
        mosi = 1'b0;
        #29;
        rst_n = 1'b1;
        #100;
        ferr0 = n_ferr;
        frame(8'h3C, 8'h00, 1, 8, 1'b0, 8'h00, c0, c1, unst);
        check("postrst_rx", {24'd0, rx_data}, 32'h3C);
        check("postrst_miso_word", {24'd0, c0}, 32'h00);
        check("postrst_no_ferr", n_ferr - ferr0, 32'd0);

        #100;
        check("rx_words_outstanding", exp_rx_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
